md_issue_ctrl: RTL and testbench

- Issue and hazard controller for the pipeline's multiply/divide unit.
- Decodes E-stage mult/multu/div/divu requests and produces a single-cycle start plus operation select for the unit.
- Times the unit's busy window (MULT_CYCLES / DIV_CYCLES) and pulses commit when HI/LO are to be written.
- Generates the D-stage stall for any HI/LO-touching instruction (mult/div/mfhi/mflo/mthi/mtlo) while the unit is starting or busy.

---
 rtl/md_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   Issue and hazard controller for the multiply/divide unit. It decodes
//   E-stage mult/multu/div/divu requests and launches the unit with a one-cycle
//   start and an op select. It then counts the unit's busy window and pulses
//   commit in the cycle the unit writes HI/LO. It also stalls any D-stage
//   HI/LO user while the unit is starting or busy.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   e_md_op      in   E-stage op: 001 mult, 010 multu, 011 div, 100 divu,
//                     any other code is no request
//   e_flush      in   E-stage instruction is being killed this cycle
//   d_md_use     in   D-stage instruction touches HI/LO or the unit
//   md_start     out  one-cycle start to the unit (combinational)
//   md_sel       out  latched op: 00 mult, 01 multu, 10 div, 11 divu
//   busy         out  unit occupied (registered)
//   commit       out  HI/LO write pulse (last busy cycle)
//   stall_d      out  freeze F/D and insert a bubble into E
//   cycles_left  out  remaining busy cycles, 0 when idle
//   proto_err    out  sticky flag: a request arrived while the unit was busy
//   op_count     out  number of committed operations (wraps)
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        e_md_op,
    input  logic              e_flush,
    input  logic              d_md_use,
    output logic              md_start,
    output logic [1:0]        md_sel,
    output logic              busy,
    output logic              commit,
    output logic              stall_d,
    output logic [CNT_W-1:0]  cycles_left,
    output logic              proto_err,
    output logic [PERF_W-1:0] op_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [1:0]         md_sel_q, md_sel_d;
    logic [CNT_W-1:0]   cycles_left_q, cycles_left_d;
    logic               proto_err_q, proto_err_d;
    logic [PERF_W-1:0]  op_count_q, op_count_d;

    logic req;
    logic is_div;
    logic start_c;
    logic commit_c;

    always_comb begin
        // Codes 101..111 fall outside the legal range and never request.
        req      = (e_md_op >= 3'd1) && (e_md_op <= 3'd4) && !e_flush;
        is_div   = (e_md_op == 3'd3) || (e_md_op == 3'd4);
        start_c  = req && (state_q == ST_IDLE);
        // The last busy cycle is the one the unit writes HI/LO.
        commit_c = (state_q == ST_RUN) && (cycles_left_q == CNT_W'(1));

        state_d       = state_q;
        busy_d        = busy_q;
        md_sel_d      = md_sel_q;
        cycles_left_d = cycles_left_q;
        proto_err_d   = proto_err_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    // Op codes 001..100 map onto select values 00..11.
                    md_sel_d      = 2'(e_md_op - 3'd1);
                    cycles_left_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d       = ST_RUN;
                    busy_d        = 1'b1;
                end
            end
            ST_RUN: begin
                cycles_left_d = cycles_left_q - CNT_W'(1);
                if (commit_c) begin
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    cycles_left_d = '0;
                    op_count_d    = op_count_q + PERF_W'(1);
                end
                // A request here should have been held off by stall_d. It is
                // dropped, and the running operation continues untouched.
                if (req) begin
                    proto_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            md_sel_q      <= 2'b00;
            cycles_left_q <= '0;
            proto_err_q   <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            md_sel_q      <= md_sel_d;
            cycles_left_q <= cycles_left_d;
            proto_err_q   <= proto_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign md_start    = start_c;
    assign commit      = commit_c;
    assign busy        = busy_q;
    assign md_sel      = md_sel_q;
    assign cycles_left = cycles_left_q;
    assign proto_err   = proto_err_q;
    assign op_count    = op_count_q;
    // The stall covers the start cycle and every busy cycle, including
    // commit. A HI/LO reader therefore only leaves D after the write.
    assign stall_d     = d_md_use && (start_c || busy_q);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
//   Directed testbench for md_issue_ctrl with default parameters
//   (MULT_CYCLES=5, DIV_CYCLES=10). Inputs change 1 ns after a rising edge.
//   Outputs are sampled on the falling edge. Expected values are written
//   from the cycle timeline of the controller.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  e_md_op;
    logic        e_flush;
    logic        d_md_use;
    logic        md_start;
    logic [1:0]  md_sel;
    logic        busy;
    logic        commit;
    logic        stall_d;
    logic [3:0]  cycles_left;
    logic        proto_err;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    md_issue_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .e_md_op     (e_md_op),
        .e_flush     (e_flush),
        .d_md_use    (d_md_use),
        .md_start    (md_start),
        .md_sel      (md_sel),
        .busy        (busy),
        .commit      (commit),
        .stall_d     (stall_d),
        .cycles_left (cycles_left),
        .proto_err   (proto_err),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Move to the next cycle. Inputs may change after this returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        e_md_op  = 3'd0;
        e_flush  = 1'b0;
        d_md_use = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Checks the busy window of an operation of latency n. The caller is in
    // cycle t+1 with no new request applied. On return the bench is in t+n+1.
    task automatic run_window(input string tag, input int n, input logic use_exp);
        for (int k = 1; k <= n; k++) begin
            sample();
            chk({tag, ".busy"},   busy, 1'b1);
            chk({tag, ".left"},   cycles_left, 32'(n - k + 1));
            chk({tag, ".commit"}, commit, (k == n));
            chk({tag, ".start"},  md_start, 1'b0);
            chk({tag, ".stall"},  stall_d, use_exp);
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        e_md_op  = 3'd0;
        e_flush  = 1'b0;
        d_md_use = 1'b0;

        // Outputs while reset is held.
        sample();
        chk("rst.busy",   busy, 1'b0);
        chk("rst.commit", commit, 1'b0);
        chk("rst.left",   cycles_left, 4'd0);
        chk("rst.sel",    md_sel, 2'b00);
        chk("rst.perr",   proto_err, 1'b0);
        chk("rst.count",  op_count, 16'd0);
        chk("rst.start",  md_start, 1'b0);
        tick();
        reset = 1'b0;

        // Single mult.
        $display("txn: mult");
        e_md_op = 3'd1;
        sample();
        chk("mult.start_t", md_start, 1'b1);
        chk("mult.busy_t",  busy, 1'b0);
        tick();
        e_md_op = 3'd0;
        run_window("mult", 5, 1'b0);
        sample();
        chk("mult.busy_end", busy, 1'b0);
        chk("mult.left_end", cycles_left, 4'd0);
        chk("mult.commit_end", commit, 1'b0);
        chk("mult.count", op_count, 16'd1);
        chk("mult.sel",   md_sel, 2'b00);

        // Div with a D-stage HI/LO user held throughout.
        $display("txn: div with d_md_use");
        do_reset();
        e_md_op  = 3'd3;
        d_md_use = 1'b1;
        sample();
        chk("div.start_t", md_start, 1'b1);
        chk("div.stall_t", stall_d, 1'b1);
        tick();
        e_md_op = 3'd0;
        run_window("div", 10, 1'b1);
        sample();
        chk("div.stall_end", stall_d, 1'b0);
        chk("div.count", op_count, 16'd1);
        chk("div.sel",   md_sel, 2'b10);
        d_md_use = 1'b0;

        // multu followed by divu in the first cycle it is accepted.
        $display("txn: multu then divu back-to-back");
        do_reset();
        e_md_op = 3'd2;
        sample();
        chk("b2b.start1", md_start, 1'b1);
        tick();
        e_md_op = 3'd0;
        run_window("b2b1", 5, 1'b0);
        e_md_op = 3'd4;
        sample();
        chk("b2b.start2", md_start, 1'b1);
        chk("b2b.sel_mid", md_sel, 2'b01);
        tick();
        e_md_op = 3'd0;
        run_window("b2b2", 10, 1'b0);
        sample();
        chk("b2b.count", op_count, 16'd2);
        chk("b2b.sel",   md_sel, 2'b11);

        // A flushed request is ignored. Codes 101..111 are ignored too.
        $display("txn: flushed mult, illegal op, then divu");
        do_reset();
        e_md_op  = 3'd1;
        e_flush  = 1'b1;
        d_md_use = 1'b1;
        sample();
        chk("flush.start", md_start, 1'b0);
        chk("flush.stall", stall_d, 1'b0);
        tick();
        e_flush = 1'b0;
        e_md_op = 3'd5;
        sample();
        chk("flush.busy", busy, 1'b0);
        chk("flush.left", cycles_left, 4'd0);
        chk("ill.start", md_start, 1'b0);
        tick();
        e_md_op  = 3'd7;
        d_md_use = 1'b0;
        sample();
        chk("ill.busy",  busy, 1'b0);
        chk("ill.start7", md_start, 1'b0);
        tick();
        e_md_op = 3'd4;
        sample();
        chk("flush.count", op_count, 16'd0);
        chk("divu.start", md_start, 1'b1);
        tick();
        e_md_op = 3'd0;
        run_window("divu", 10, 1'b0);
        sample();
        chk("divu.count", op_count, 16'd1);
        chk("divu.sel",   md_sel, 2'b11);

        // A request while busy is a protocol error.
        $display("txn: mult with div forced at t+2");
        do_reset();
        e_md_op = 3'd1;
        sample();
        chk("perr.start_t", md_start, 1'b1);
        tick();
        e_md_op = 3'd0;
        sample();
        chk("perr.left1", cycles_left, 4'd5);
        tick();
        e_md_op = 3'd3;
        sample();
        chk("perr.start2", md_start, 1'b0);
        chk("perr.flag_t2", proto_err, 1'b0);
        tick();
        e_md_op = 3'd0;
        sample();
        chk("perr.flag_t3", proto_err, 1'b1);
        chk("perr.left3", cycles_left, 4'd3);
        tick();
        tick();
        sample();
        chk("perr.commit5", commit, 1'b1);
        chk("perr.sel5", md_sel, 2'b00);
        tick();
        sample();
        chk("perr.count", op_count, 16'd1);
        chk("perr.sticky", proto_err, 1'b1);
        chk("perr.busy_end", busy, 1'b0);

        // Asynchronous reset in the middle of a div.
        $display("txn: div aborted by reset at t+3");
        do_reset();
        e_md_op = 3'd3;
        tick();
        e_md_op = 3'd0;
        tick();
        tick();
        sample();
        chk("abort.left_pre", cycles_left, 4'd8);
        #1 reset = 1'b1;
        #1;
        chk("abort.busy_async", busy, 1'b0);
        chk("abort.left_async", cycles_left, 4'd0);
        chk("abort.commit",     commit, 1'b0);
        tick();
        sample();
        chk("abort.count", op_count, 16'd0);
        tick();
        reset   = 1'b0;
        e_md_op = 3'd1;
        sample();
        chk("abort.restart", md_start, 1'b1);
        tick();
        e_md_op = 3'd0;
        run_window("remult", 5, 1'b0);
        sample();
        chk("remult.count", op_count, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
